// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache refill definitions: refill FSM states, default geometry and
// the line-offset helper.
package cache_refill_ctrl_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int WORDS_PER_LINE = 4;

  function automatic int line_off(input int words);
    return $clog2(words) + 2;
  endfunction

  localparam int OFF = line_off(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Cache/memory/core-side signal bundle of the refill controller.
// The controller takes the master view; the environment takes the slave view.
interface cache_refill_ctrl_if
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = cache_refill_ctrl_pkg::ADDR_W,
  parameter int DATA_W = cache_refill_ctrl_pkg::DATA_W
) ();

  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              crit_valid;
  logic [DATA_W-1:0] crit_data;
  logic              fill_done;
  logic              protocol_err;
  logic [31:0]       miss_count;

  modport master (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr, fill_we, fill_addr,
           fill_data, crit_valid, crit_data, fill_done, protocol_err, miss_count
  );

  modport slave (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_we, fill_addr,
           fill_data, crit_valid, crit_data, fill_done, protocol_err, miss_count
  );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: one line-aligned burst per miss, in-order
// line fill with critical-word forwarding, and a running miss counter.
//
// state  | meaning
// S_IDLE | ready for a miss (miss_ready=1)
// S_REQ  | burst request held until memory accepts it
// S_WAIT | collecting beats, one cache write per beat
// S_DONE | last write visible; fill_done pulses next cycle
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W         = cache_refill_ctrl_pkg::ADDR_W,
  parameter int DATA_W         = cache_refill_ctrl_pkg::DATA_W,
  parameter int WORDS_PER_LINE = cache_refill_ctrl_pkg::WORDS_PER_LINE
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_refill_ctrl_if.master bus
);

  localparam int OFF_L  = line_off(WORDS_PER_LINE);
  localparam int BEAT_W = OFF_L - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  refill_state_e     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [BEAT_W-1:0] crit_idx_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [31:0]       miss_count_q;
  logic              protocol_err_q;
  logic              mem_req_valid_q;
  logic              fill_we_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [DATA_W-1:0] fill_data_q;
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;
  logic              fill_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      crit_idx_q      <= '0;
      beat_cnt_q      <= '0;
      miss_count_q    <= '0;
      protocol_err_q  <= 1'b0;
      mem_req_valid_q <= 1'b0;
      fill_we_q       <= 1'b0;
      fill_addr_q     <= '0;
      fill_data_q     <= '0;
      crit_valid_q    <= 1'b0;
      crit_data_q     <= '0;
      fill_done_q     <= 1'b0;
    end else begin
      fill_we_q    <= 1'b0;
      crit_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;

      // A beat in any state but S_WAIT (even alongside mem_req_ready) is a protocol violation.
      if (bus.mem_rsp_valid && (state_q != S_WAIT))
        protocol_err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.miss_valid) begin
            base_q          <= {bus.miss_addr[ADDR_W-1:OFF_L], {OFF_L{1'b0}}};
            crit_idx_q      <= bus.miss_addr[OFF_L-1:2];
            miss_count_q    <= miss_count_q + 32'd1;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            fill_we_q   <= 1'b1;
            fill_addr_q <= base_q | ADDR_W'({beat_cnt_q, 2'b00});
            fill_data_q <= bus.mem_rsp_data;
            if (beat_cnt_q == crit_idx_q) begin
              crit_valid_q <= 1'b1;
              crit_data_q  <= bus.mem_rsp_data;
            end
            // Power-of-two line: the counter wraps to 0 on the final beat.
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT)
              state_q <= S_DONE;
          end
        end
        S_DONE: begin
          fill_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.miss_ready    = (state_q == S_IDLE);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = base_q;
  assign bus.fill_we       = fill_we_q;
  assign bus.fill_addr     = fill_addr_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.crit_valid    = crit_valid_q;
  assign bus.crit_data     = crit_data_q;
  assign bus.fill_done     = fill_done_q;
  assign bus.protocol_err  = protocol_err_q;
  assign bus.miss_count    = miss_count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed refill scenarios plus
// randomized misses against a transaction-level model of expected cache writes.
module tb_cache_refill_ctrl;

  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          crit;
  } wr_t;

  wr_t wq[$];
  int  exp_count   = 0;
  int  crit_seen   = 0;
  int  last_we_cyc = -10;
  int  cyc         = 0;
  bit  mon_en      = 0;

  always @(posedge clk) cyc++;

  // Every cache write must match the next expected word of the line.
  wr_t w;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.fill_we) begin
        if (wq.size() == 0) begin
          chk("unexp_we", bus.fill_we, 1'b0);
        end else begin
          w = wq.pop_front();
          chk("fill_addr", bus.fill_addr, w.addr);
          chk("fill_data", bus.fill_data, w.data);
          chk("crit_valid", bus.crit_valid, w.crit);
          if (w.crit) chk("crit_data", bus.crit_data, w.data);
        end
        last_we_cyc = cyc;
      end else if (bus.crit_valid) begin
        chk("crit_no_we", bus.crit_valid, 1'b0);
      end
      if (bus.crit_valid) crit_seen++;
      if (bus.fill_done) begin
        chk("done_lat", cyc - last_we_cyc, 1);
        chk("done_pending", wq.size(), 0);
        chk("crit_cnt", crit_seen, 1);
        crit_seen = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.miss_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    tick();
    tick();
    wq.delete();
    crit_seen = 0;
    exp_count = 0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_accept(input logic [31:0] addr, output bit ok);
    int n;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    n = 0;
    while (!bus.miss_ready && n < 100) begin
      tick();
      n++;
    end
    ok = bus.miss_ready;
    if (!ok) begin
      chk("ready_timeout", bus.miss_ready, 1'b1);
      bus.miss_valid = 1'b0;
    end else begin
      tick();
      exp_count++;
    end
  endtask

  // One full refill. Ends in the fill_done cycle without advancing past it.
  task automatic do_miss(input logic [31:0] addr, input int stall, input int gmin,
                         input int gmax, input bit fixed, input bit hold_next,
                         input logic [31:0] next_addr);
    logic [31:0] base, d;
    int crit, g;
    bit ok;
    wr_t e;
    base = addr - (addr % LINE_BYTES);
    crit = (addr % LINE_BYTES) / 4;
    wait_accept(addr, ok);
    if (!ok) return;
    if (hold_next) bus.miss_addr = next_addr;
    else bus.miss_valid = 1'b0;
    chk("req_valid", bus.mem_req_valid, 1'b1);
    chk("req_addr", bus.mem_req_addr, base);
    chk("ready_busy", bus.miss_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("req_valid_stall", bus.mem_req_valid, 1'b1);
      chk("req_addr_stall", bus.mem_req_addr, base);
      chk("ready_busy", bus.miss_ready, 1'b0);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < WPL; i++) begin
      g = $urandom_range(gmax, gmin);
      repeat (g) begin
        bus.mem_rsp_data = $urandom();
        tick();
        chk("ready_busy", bus.miss_ready, 1'b0);
      end
      d = fixed ? 32'hA0 + 32'(i) : $urandom();
      e.addr = base + 32'(4 * i);
      e.data = d;
      e.crit = (i == crit);
      wq.push_back(e);
      if (i == 0) chk("req_dropped", bus.mem_req_valid, 1'b0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d;
      tick();
      bus.mem_rsp_valid = 1'b0;
    end
    chk("ready_done", bus.miss_ready, 1'b0);
    chk("done_early", bus.fill_done, 1'b0);
    tick();
    chk("fill_done", bus.fill_done, 1'b1);
    chk("miss_count", bus.miss_count, exp_count);
    chk("ready_after", bus.miss_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [31:0] d;
    wr_t e;
    rst_n = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_addr = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    tick();
    tick();
    chk("rst_ready", bus.miss_ready, 1'b1);
    chk("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_fill_we", bus.fill_we, 1'b0);
    chk("rst_done", bus.fill_done, 1'b0);
    chk("rst_perr", bus.protocol_err, 1'b0);
    chk("rst_count", bus.miss_count, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Basic refill with a second miss held pending behind it.
    do_miss(32'h0000_1234, 0, 0, 0, 1, 1, 32'h0000_2000);
    do_miss(32'h0000_2000, 0, 0, 0, 0, 0, 32'h0);
    chk("count_two", bus.miss_count, 2);
    tick();

    // Stalled request, one idle cycle between beats.
    do_miss(32'h0000_4568, 5, 1, 1, 0, 0, 32'h0);
    tick();

    // Critical word last.
    do_miss(32'h0000_100C, 0, 0, 0, 1, 0, 32'h0);

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(2, 0)) tick();
      do_miss($urandom(), $urandom_range(3, 0), 0, 2, 0, 0, 32'h0);
    end
    chk("perr_clean", bus.protocol_err, 1'b0);
    tick();

    // Reset after two beats.
    wait_accept(32'h0000_5554, ok);
    bus.miss_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom();
      e.addr = 32'h0000_5550 + 32'(4 * i);
      e.data = d;
      e.crit = (i == 1);
      wq.push_back(e);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data = d;
      tick();
      bus.mem_rsp_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bus.fill_we, 1'b0);
    chk("mid_rst_faddr", bus.fill_addr, 0);
    chk("mid_rst_fdata", bus.fill_data, 0);
    chk("mid_rst_crit", bus.crit_valid, 1'b0);
    chk("mid_rst_cdata", bus.crit_data, 0);
    chk("mid_rst_req", bus.mem_req_valid, 1'b0);
    chk("mid_rst_raddr", bus.mem_req_addr, 0);
    chk("mid_rst_count", bus.miss_count, 0);
    chk("mid_rst_ready", bus.miss_ready, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_done", bus.fill_done, 1'b0);
      tick();
    end
    do_miss(32'h0000_7778, 1, 0, 1, 0, 0, 32'h0);
    tick();

    // Unexpected beat in IDLE.
    chk("perr_pre", bus.protocol_err, 1'b0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("perr_set", bus.protocol_err, 1'b1);
    chk("perr_no_we", bus.fill_we, 1'b0);
    repeat (3) tick();
    chk("perr_sticky", bus.protocol_err, 1'b1);
    do_miss(32'h0000_9990, 0, 0, 1, 0, 0, 32'h0);
    chk("perr_sticky2", bus.protocol_err, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
